// File: rtl/trig_pulse_scheduler.sv
// Round-robin scheduler for a shared stretched-pulse trigger channel.
// Each grant produces PULSE_LEN high cycles followed by at least GAP_LEN
// low cycles so the slow receiving domain never merges or drops pulses.
//
// state | meaning
// IDLE  | no pulse in flight, waiting for en and a pending request
// PULSE | pulse_out high, counter runs down PULSE_LEN cycles
// GAP   | pulse_out low, counter runs down GAP_LEN cycles
module trig_pulse_scheduler #(
    parameter int NUM_REQ   = 4,
    parameter int ID_W      = 2,
    parameter int PULSE_LEN = 10,
    parameter int GAP_LEN   = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_in,
    input  logic               en,
    input  logic               clr_ovf,
    output logic               pulse_out,
    output logic [ID_W-1:0]    pulse_id,
    output logic [NUM_REQ-1:0] grant,
    output logic               busy,
    output logic [NUM_REQ-1:0] pend,
    output logic [NUM_REQ-1:0] ovf
);

    localparam int MAX_LEN = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);
    localparam int SCAN_W  = ID_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [ID_W-1:0]    ptr, winner;
    logic [SCAN_W-1:0]  scan_idx;
    logic [NUM_REQ-1:0] req_prev, req_rise, win_mask;
    logic               do_grant;

    assign req_rise = req_in & ~req_prev;
    assign busy     = (state != IDLE);
    assign win_mask = do_grant ? (NUM_REQ'(1) << winner) : '0;

    // Pick the first pending requester at or after ptr; scanning backwards
    // lets the closest one to ptr overwrite the others.
    always_comb begin
        winner   = ptr;
        scan_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan_idx = {1'b0, ptr} + SCAN_W'(k);
            if (scan_idx >= SCAN_W'(NUM_REQ)) begin
                scan_idx = scan_idx - SCAN_W'(NUM_REQ);
            end
            if (pend[scan_idx[ID_W-1:0]]) begin
                winner = scan_idx[ID_W-1:0];
            end
        end
    end

    // Next-state logic; a grant is only issued from IDLE or at the end of GAP.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        do_grant  = 1'b0;
        case (state)
            IDLE: begin
                if (en && |pend) begin
                    do_grant  = 1'b1;
                    state_nxt = PULSE;
                    cnt_nxt   = CNT_W'(PULSE_LEN - 1);
                end
            end
            PULSE: begin
                if (cnt == '0) begin
                    state_nxt = GAP;
                    cnt_nxt   = CNT_W'(GAP_LEN - 1);
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    if (en && |pend) begin
                        do_grant  = 1'b1;
                        state_nxt = PULSE;
                        cnt_nxt   = CNT_W'(PULSE_LEN - 1);
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State and timer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Registered channel outputs and round-robin pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pulse_out <= 1'b0;
            grant     <= '0;
            pulse_id  <= '0;
            ptr       <= '0;
        end else begin
            pulse_out <= (state_nxt == PULSE);
            grant     <= win_mask;
            if (do_grant) begin
                pulse_id <= winner;
                ptr      <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
            end
        end
    end

    // Edge capture into pending flags; a fresh edge beats the grant clear
    // and is not an overflow, since the old request is being served now.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_prev <= '0;
            pend     <= '0;
            ovf      <= '0;
        end else begin
            req_prev <= req_in;
            pend     <= (pend & ~win_mask) | req_rise;
            ovf      <= (clr_ovf ? '0 : ovf) | (req_rise & pend & ~win_mask);
        end
    end

endmodule

// File: tb/tb_trig_pulse_scheduler.sv
// Bench for trig_pulse_scheduler: directed scenarios plus random traffic,
// every cycle compared against a timeline model of the channel.
module tb_trig_pulse_scheduler;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int PL = 10;
    localparam int GL = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  req_in = '0;
    logic          en = 1'b1;
    logic          clr_ovf = 1'b0;
    logic          pulse_out;
    logic [IW-1:0] pulse_id;
    logic [N-1:0]  grant;
    logic          busy;
    logic [N-1:0]  pend;
    logic [N-1:0]  ovf;

    int n_chk  = 0;
    int n_pass = 0;

    trig_pulse_scheduler #(
        .NUM_REQ(N), .ID_W(IW), .PULSE_LEN(PL), .GAP_LEN(GL)
    ) dut (
        .clk(clk), .rst(rst), .req_in(req_in), .en(en), .clr_ovf(clr_ovf),
        .pulse_out(pulse_out), .pulse_id(pulse_id), .grant(grant),
        .busy(busy), .pend(pend), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    endtask

    // Reference model: age counts cycles since the last grant; the channel
    // is high for age < PL, busy for age < PL+GL, and free again once a
    // full period has elapsed.
    logic [N-1:0] m_prev, m_pend, m_ovf, m_grant, m_rise, m_clr;
    int           m_ptr, m_id, m_age, m_w;
    logic         m_g;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_prev = '0; m_pend = '0; m_ovf = '0; m_grant = '0;
            m_ptr = 0; m_id = 0; m_age = PL + GL;
        end else begin
            m_rise = req_in & ~m_prev;
            m_g = (m_age >= PL + GL - 1) && en && (m_pend != '0);
            m_w = -1;
            if (m_g) begin
                for (int k = 0; k < N; k++)
                    if (m_w < 0 && m_pend[(m_ptr + k) % N]) m_w = (m_ptr + k) % N;
            end
            m_clr = '0;
            if (m_g) m_clr[m_w] = 1'b1;
            m_ovf  = (clr_ovf ? '0 : m_ovf) | (m_rise & m_pend & ~m_clr);
            m_pend = (m_pend & ~m_clr) | m_rise;
            m_grant = m_clr;
            if (m_g) begin
                m_id  = m_w;
                m_ptr = (m_w + 1) % N;
                m_age = 0;
            end else if (m_age < PL + GL) begin
                m_age++;
            end
            m_prev = req_in;
        end
    end

    // Per-cycle comparison against the model, plus pulse/id bookkeeping.
    int   n_pulse = 0;
    logic po_last = 1'b0;
    int   ids[$];

    always @(negedge clk) begin
        chk("pulse_out", 32'(pulse_out), 32'(m_age < PL));
        chk("busy",      32'(busy),      32'(m_age < PL + GL));
        chk("grant",     32'(grant),     32'(m_grant));
        chk("pulse_id",  32'(pulse_id),  32'(m_id));
        chk("pend",      32'(pend),      32'(m_pend));
        chk("ovf",       32'(ovf),       32'(m_ovf));
        if (pulse_out && !po_last) begin
            n_pulse++;
            ids.push_back(int'(pulse_id));
        end
        po_last = pulse_out;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        #2 rst = 1'b0;
        step(3);
        rst = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, ib;
        logic [N-1:0] flip;

        // reset with no requests: channel must stay quiet
        step(2);
        rst = 1'b1;
        base = n_pulse;
        step(50);
        chk("idle_pulses", 32'(n_pulse - base), 32'd0);

        // req_in[1] held high through reset release counts as one request
        req_in = 4'b0010;
        reset_dut();
        base = n_pulse; ib = ids.size();
        step(60);
        chk("held_pulses", 32'(n_pulse - base), 32'd1);
        if (ids.size() > ib) chk("held_id", 32'(ids[ib]), 32'd1);
        else chk("held_id", 32'hffff_ffff, 32'd1);

        // single request on id 2
        req_in = '0;
        step(2);
        req_in = 4'b0100;
        step(1);
        chk("single_pend", 32'(pend), 32'h4);
        step(1);
        chk("single_grant", 32'(grant), 32'h4);
        chk("single_pulse", 32'(pulse_out), 32'd1);
        step(30);

        // all requesters at once from a fresh pointer: ids 0,1,2,3 in order
        req_in = '0;
        reset_dut();
        base = n_pulse; ib = ids.size();
        req_in = 4'b1111;
        step(4 * (PL + GL) + 10);
        chk("rr_pulses", 32'(n_pulse - base), 32'd4);
        for (int i = 0; i < 4; i++)
            if (ids.size() > ib + i) chk("rr_order", 32'(ids[ib + i]), 32'(i));
        chk("rr_pend", 32'(pend), 32'd0);
        chk("rr_idle", 32'(busy), 32'd0);

        // overflow: two edges on id 0 while id 1 is being served
        req_in = '0;
        step(2);
        base = n_pulse;
        req_in = 4'b0010;
        step(3);
        req_in = 4'b0011; step(1);
        req_in = 4'b0010; step(1);
        req_in = 4'b0011; step(1);
        chk("ovf_set", 32'(ovf[0]), 32'd1);
        step(2 * (PL + GL) + 5);
        chk("ovf_merge", 32'(n_pulse - base), 32'd2);
        clr_ovf = 1'b1; step(1); clr_ovf = 1'b0;
        chk("ovf_clr", 32'(ovf), 32'd0);
        en = 1'b0;
        req_in = '0;     step(1);
        req_in = 4'b0001; step(1);
        req_in = '0;     step(1);
        req_in = 4'b0001; clr_ovf = 1'b1; step(1);
        clr_ovf = 1'b0;
        chk("ovf_set_wins", 32'(ovf[0]), 32'd1);
        en = 1'b1;
        step(PL + GL + 5);

        // enable gating holds the request until en rises
        req_in = '0;
        reset_dut();
        en = 1'b0;
        base = n_pulse;
        req_in = 4'b0010;
        step(100);
        chk("gate_pulses", 32'(n_pulse - base), 32'd0);
        chk("gate_pend", 32'(pend), 32'h2);
        en = 1'b1;
        step(1);
        chk("gate_start", 32'(pulse_out), 32'd1);
        step(PL + GL + 2);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            flip = '0;
            for (int i = 0; i < N; i++) flip[i] = ($urandom_range(15) == 0);
            req_in  = req_in ^ flip;
            en      = ($urandom_range(9) != 0);
            clr_ovf = ($urandom_range(19) == 0);
            step(1);
        end
        clr_ovf = 1'b0;
        en = 1'b1;

        // asynchronous reset in the middle of a pulse
        req_in = '0;
        step(PL + GL + 2);
        req_in = 4'b0001;
        for (int i = 0; i < 3 * (PL + GL) && !pulse_out; i++) step(1);
        chk("mid_pulse_seen", 32'(pulse_out), 32'd1);
        step(4);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_pulse", 32'(pulse_out), 32'd0);
        chk("mid_rst_pend", 32'(pend), 32'd0);
        chk("mid_rst_ovf", 32'(ovf), 32'd0);
        req_in = '0;
        step(3);
        rst = 1'b1;
        base = n_pulse;
        step(40);
        chk("mid_rst_residual", 32'(n_pulse - base), 32'd0);
        ib = ids.size();
        req_in = 4'b0110;
        step(PL + GL + 5);
        if (ids.size() > ib) chk("mid_rst_ptr", 32'(ids[ib]), 32'd1);
        else chk("mid_rst_ptr", 32'hffff_ffff, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
